// File: rtl/chroma_key_pipe.sv
// chroma_key_pipe: two-stage chroma keyer with hysteresis, frame-synchronous config and keyed-pixel counter
module chroma_key_pipe #(
  parameter int CW    = 8,
  parameter int HYST  = 4,
  parameter int CNT_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_sol,
  input  logic [3*CW-1:0]   in_pixel,
  input  logic [3*CW-1:0]   pass_in,
  input  logic [3*CW-1:0]   cfg_lo,
  input  logic [3*CW-1:0]   cfg_hi,
  input  logic [3*CW-1:0]   cfg_fill,
  input  logic              cfg_load,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_sol,
  output logic [3*CW-1:0]   out_pixel,
  output logic [3*CW-1:0]   pass_out,
  output logic              out_keyed,
  output logic [CNT_W-1:0]  key_count,
  output logic              count_valid
);
  localparam int PW = 3*CW;
  localparam logic [CW-1:0] MAXV = '1;
  localparam logic [CW-1:0] HV = CW'(HYST);
  logic [PW-1:0] sh_lo, sh_hi, sh_fill, ac_lo, ac_hi, ac_fill, lo, hi, fill;
  logic [CW-1:0] c, l, h, lw, hw;
  logic mn, mw;
  logic v1, sof1, sol1, mn1, mw1, pk, key;
  logic [PW-1:0] pix1, pass1, fill1;
  logic [CNT_W-1:0] cnt;
  // a valid sof switches to the shadow config combinationally so its own pixel already uses it
  always_comb begin
    lo = (in_valid && in_sof) ? sh_lo : ac_lo;
    hi = (in_valid && in_sof) ? sh_hi : ac_hi;
    fill = (in_valid && in_sof) ? sh_fill : ac_fill;
    c = '0;
    l = '0;
    h = '0;
    lw = '0;
    hw = '0;
    mn = 1'b1;
    mw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c = in_pixel[i*CW +: CW];
      l = lo[i*CW +: CW];
      h = hi[i*CW +: CW];
      lw = (l < HV) ? '0 : l - HV;
      hw = (h > MAXV - HV) ? MAXV : h + HV;
      mn = mn & (c >= l) & (c <= h);
      mw = mw & (c >= lw) & (c <= hw);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {sh_lo, sh_hi, sh_fill, ac_lo, ac_hi, ac_fill} <= '0;
      {v1, sof1, sol1, mn1, mw1} <= '0;
      {pix1, pass1, fill1} <= '0;
    end else begin
      v1 <= in_valid;
      sof1 <= in_valid & in_sof;
      sol1 <= in_valid & in_sol;
      pix1 <= in_pixel;
      pass1 <= pass_in;
      mn1 <= mn;
      mw1 <= mw;
      fill1 <= fill;
      ac_lo <= lo;
      ac_hi <= hi;
      ac_fill <= fill;
      if (cfg_load) begin
        sh_lo <= cfg_lo;
        sh_hi <= cfg_hi;
        sh_fill <= cfg_fill;
      end
    end
  end
  assign key = en & v1 & (mn1 | (~sol1 & pk & mw1));
  always_ff @(posedge clk) begin
    if (rst) begin
      {out_valid, out_sof, out_sol, out_keyed, count_valid, pk} <= '0;
      {out_pixel, pass_out} <= '0;
      key_count <= '0;
      cnt <= '0;
    end else begin
      out_valid <= v1;
      out_sof <= sof1;
      out_sol <= sol1;
      out_pixel <= key ? fill1 : pix1;
      pass_out <= pass1;
      out_keyed <= key;
      count_valid <= v1 & sof1;
      if (v1) pk <= key;
      if (v1 && sof1) begin
        key_count <= cnt;
        cnt <= CNT_W'(key);
      end else if (key && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule
